// File: rtl/sparc_ifu_thrfsm_bank.sv
// Bank of NTHR IFU thread switch FSMs with WAIT watchdogs, decoded ready/run vectors,
// multi-runner and illegal-state checks. Define IFU_THRFSM_SPEC_EN to enable SPEC_RDY/SPEC_RUN.
module sparc_ifu_thrfsm_bank #(
  parameter int NTHR      = 4,
  parameter int TMO_W     = 10,
  parameter int TMO_LIMIT = 1000
) (
  input  logic              clk,
  input  logic              arst_l,
  input  logic [NTHR-1:0]   completion,
  input  logic [NTHR-1:0]   schedule,
  input  logic [NTHR-1:0]   spec_ld,
  input  logic [NTHR-1:0]   ldhit,
  input  logic [NTHR-1:0]   stall,
  input  logic [NTHR-1:0]   int_activate,
  input  logic [NTHR-1:0]   halt_thread,
  input  logic [NTHR-1:0]   start_thread,
  input  logic [NTHR-1:0]   thaw_thread,
  input  logic [NTHR-1:0]   nuke_thread,
  input  logic [NTHR-1:0]   rst_thread,
  input  logic              switch_out,
  input  logic              sw_cond,
  output logic [5*NTHR-1:0] thr_state,
  output logic [NTHR-1:0]   thr_rdy,
  output logic [NTHR-1:0]   thr_run,
  output logic [NTHR-1:0]   thr_wait_tmo,
  output logic              multi_run_err,
  output logic              illegal_err
);

  typedef enum logic [4:0] {
    IDLE     = 5'b00000,
    WAIT     = 5'b00001,
    HALT     = 5'b00010,
    RUN      = 5'b00101,
    SPEC_RUN = 5'b00111,
    SPEC_RDY = 5'b10011,
    RDY      = 5'b11001
  } thr_st_e;

  typedef struct packed {
    logic completion;
    logic schedule;
    logic spec_ld;
    logic ldhit;
    logic stall;
    logic int_activate;
    logic halt;
    logic start;
    logic thaw;
    logic nuke;
    logic rst;
  } thr_ev_t;

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_LIMIT);

  logic [5*NTHR-1:0] state_q, state_d;
  logic [TMO_W-1:0]  cnt_q [NTHR];
  logic [TMO_W-1:0]  cnt_d [NTHR];
  logic              any_ill;
  logic [3:0]        n_run;

  function automatic logic is_legal(input logic [4:0] s);
    logic ok;
    case (s)
      IDLE, WAIT, HALT, RUN, RDY: ok = 1'b1;
`ifdef IFU_THRFSM_SPEC_EN
      SPEC_RDY, SPEC_RUN:         ok = 1'b1;
`endif
      default:                    ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] c);
    return (c == TMO_LIM) ? c : c + TMO_W'(1);
  endfunction

  // switch_out/sw_cond only appear in the running states, so idle threads ignore them
  function automatic logic [4:0] next_st(input logic [4:0] cur, input thr_ev_t ev,
                                         input logic sw_out, input logic sw_wait);
    logic [4:0] nxt;
    nxt = cur;
    case (cur)
      IDLE: begin
        if (ev.rst || ev.thaw)          nxt = WAIT;
        else if (ev.start)              nxt = RDY;
      end
      HALT: begin
        if (ev.nuke)                    nxt = IDLE;
        else if (ev.rst || ev.thaw)     nxt = WAIT;
        else if (ev.int_activate || ev.start) nxt = RDY;
      end
      RDY: begin
        if (ev.stall)                   nxt = WAIT;
        else if (ev.schedule)           nxt = RUN;
      end
      RUN: begin
        if (ev.stall || sw_wait)        nxt = WAIT;
        else if (sw_out)                nxt = RDY;
      end
      WAIT: begin
        if (ev.nuke)                    nxt = IDLE;
        else if (ev.halt)               nxt = HALT;
        else if (ev.stall)              nxt = WAIT;
`ifdef IFU_THRFSM_SPEC_EN
        else if (ev.spec_ld)            nxt = SPEC_RDY;
`endif
        else if (ev.completion)         nxt = RDY;
      end
`ifdef IFU_THRFSM_SPEC_EN
      SPEC_RDY: begin
        if (ev.stall)                   nxt = WAIT;
        else if (ev.schedule && !ev.ldhit) nxt = SPEC_RUN;
        else if (ev.schedule)           nxt = RUN;
        else if (ev.ldhit)              nxt = RDY;
      end
      SPEC_RUN: begin
        if (ev.stall || sw_wait)        nxt = WAIT;
        else if (ev.ldhit && sw_out)    nxt = RDY;
        else if (ev.ldhit)              nxt = RUN;
        else if (sw_out)                nxt = SPEC_RDY;
      end
`endif
      default:                          nxt = ev.rst ? WAIT : IDLE;
    endcase
    return nxt;
  endfunction

  always_comb begin
    state_d = state_q;
    any_ill = 1'b0;
    for (int i = 0; i < NTHR; i++) begin
      thr_ev_t    ev;
      logic [4:0] cur;
      logic [4:0] nxt;
      ev = '{completion: completion[i], schedule: schedule[i], spec_ld: spec_ld[i],
             ldhit: ldhit[i], stall: stall[i], int_activate: int_activate[i],
             halt: halt_thread[i], start: start_thread[i], thaw: thaw_thread[i],
             nuke: nuke_thread[i], rst: rst_thread[i]};
      cur = state_q[5*i +: 5];
      nxt = next_st(cur, ev, switch_out, sw_cond);
      state_d[5*i +: 5] = nxt;
      if (!is_legal(cur)) any_ill = 1'b1;
      // Counter only survives a WAIT->WAIT edge; entering or leaving WAIT restarts it
      cnt_d[i] = ((cur == WAIT) && (nxt == WAIT)) ? sat_inc(cnt_q[i]) : '0;
    end
  end

  always_comb begin
    thr_rdy      = '0;
    thr_run      = '0;
    thr_wait_tmo = '0;
    n_run        = '0;
    for (int i = 0; i < NTHR; i++) begin
      thr_rdy[i] = (state_q[5*i +: 5] == RDY);
`ifdef IFU_THRFSM_SPEC_EN
      thr_run[i] = (state_q[5*i +: 5] == RUN) || (state_q[5*i +: 5] == SPEC_RUN);
`else
      thr_run[i] = (state_q[5*i +: 5] == RUN);
`endif
      thr_wait_tmo[i] = (TMO_LIMIT != 0) && (cnt_q[i] == TMO_LIM);
      n_run = n_run + 4'(thr_run[i]);
    end
  end

  assign thr_state = state_q;

  // Stage boundary: per-thread state, watchdogs and checker flags
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      state_q       <= '0;
      multi_run_err <= 1'b0;
      illegal_err   <= 1'b0;
      for (int i = 0; i < NTHR; i++) cnt_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      multi_run_err <= (n_run > 4'd1);
      illegal_err   <= any_ill;
      for (int i = 0; i < NTHR; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule
